param_weight_buffer: RTL and testbench

PARAM_WEIGHT_BUFFER -- requirements
Module: param_weight_buffer

---
 rtl/param_weight_buffer.sv | 165 ++++++++++++++++
 tb/tb_param_weight_buffer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/param_weight_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : param_weight_buffer
//  Purpose  : Double-buffered weight store for a PE array. Weight beats of
//             WPB words fill a shadow bank; a swap copies the complete shadow
//             set into the active bank in one cycle. Each of the LANES
//             outputs shows active[lane][tap], where the tap index steps
//             through 0..TAPS-1 under en_cnt.
//  Ports    : clk            - single clock, rising edge
//             rst            - synchronous active-high reset
//             weight_valid   - input beat valid
//             weight_i       - input beat, word j at [(j+1)*DW-1 -: DW]
//             weight_ready   - shadow bank accepts a beat (FILL state)
//             swap           - promote shadow bank to active
//             en_cnt         - advance the tap read index
//             shadow_full    - shadow bank holds a complete set (FULL state)
//             active_valid   - active bank holds a promoted set
//             tap_last       - tap index equals TAPS-1
//             para_weight_o  - lane l at [(l+1)*DW-1 -: DW]
//  Revision : 1.0 - initial release
// ============================================================================
module param_weight_buffer #(
  parameter int DW    = 8,
  parameter int LANES = 11,
  parameter int TAPS  = 7,
  parameter int WPB   = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 weight_valid,
  input  logic [WPB*DW-1:0]    weight_i,
  output logic                 weight_ready,
  input  logic                 swap,
  input  logic                 en_cnt,
  output logic                 shadow_full,
  output logic                 active_valid,
  output logic                 tap_last,
  output logic [LANES*DW-1:0]  para_weight_o
);

  localparam int c_NWORDS = LANES * TAPS;
  localparam int c_NBEATS = (c_NWORDS + WPB - 1) / WPB;
  localparam int c_TIW    = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int c_BCW    = $clog2(c_NBEATS + 1);

  localparam logic [0:0] c_ST_FILL = 1'b0;
  localparam logic [0:0] c_ST_FULL = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [c_BCW-1:0] beat_cnt_q, beat_cnt_d;
  logic [c_TIW-1:0] tap_q, tap_d;
  logic             active_valid_q, active_valid_d;

  logic w_accept;
  logic w_swap_acc;
  logic w_last_beat;

  assign w_accept    = weight_valid & weight_ready;
  assign w_swap_acc  = swap & shadow_full;
  assign w_last_beat = (beat_cnt_q == c_BCW'(c_NBEATS - 1));

  // --------------------------------------------------------------------------
  // Fill FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= c_ST_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Fill FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_FILL: if (w_accept && w_last_beat) state_d = c_ST_FULL;
      c_ST_FULL: if (w_swap_acc)              state_d = c_ST_FILL;
      default:                                state_d = c_ST_FILL;
    endcase
  end

  // Fill FSM: outputs
  always_comb begin
    weight_ready = (state_q == c_ST_FILL);
    shadow_full  = (state_q == c_ST_FULL);
  end

  // --------------------------------------------------------------------------
  // Beat counter, tap index and active-valid flag
  // --------------------------------------------------------------------------
  always_comb begin
    beat_cnt_d     = beat_cnt_q;
    tap_d          = tap_q;
    active_valid_d = active_valid_q;

    if (w_swap_acc) begin
      beat_cnt_d = '0;
    end else if (w_accept) begin
      beat_cnt_d = beat_cnt_q + 1'b1;
    end

    // A swap restarts the read at tap 0 even if en_cnt is also high.
    if (w_swap_acc) begin
      tap_d          = '0;
      active_valid_d = 1'b1;
    end else if (en_cnt) begin
      if (tap_q == c_TIW'(TAPS - 1)) tap_d = '0;
      else                           tap_d = tap_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_q     <= '0;
      tap_q          <= '0;
      active_valid_q <= 1'b0;
    end else begin
      beat_cnt_q     <= beat_cnt_d;
      tap_q          <= tap_d;
      active_valid_q <= active_valid_d;
    end
  end

  assign active_valid = active_valid_q;
  assign tap_last     = (tap_q == c_TIW'(TAPS - 1));

  // --------------------------------------------------------------------------
  // Weight banks. Storage word k = lane*TAPS + tap is written only by beat
  // k/WPB from beat word k%WPB, so every register has a fixed source slice.
  // Beat words that map past the last storage word simply have no register.
  // --------------------------------------------------------------------------
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [DW-1:0] w_taps [TAPS];

    for (genvar t = 0; t < TAPS; t++) begin : g_tap
      localparam int c_K    = l * TAPS + t;
      localparam int c_BEAT = c_K / WPB;
      localparam int c_WORD = c_K % WPB;

      logic [DW-1:0] shadow_q;
      logic [DW-1:0] active_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          shadow_q <= '0;
          active_q <= '0;
        end else begin
          if (w_accept && (beat_cnt_q == c_BCW'(c_BEAT))) begin
            shadow_q <= weight_i[c_WORD*DW +: DW];
          end
          if (w_swap_acc) begin
            active_q <= shadow_q;
          end
        end
      end

      assign w_taps[t] = active_q;
    end

    assign para_weight_o[l*DW +: DW] = w_taps[tap_q];
  end

endmodule
`default_nettype wire

// File: tb/tb_param_weight_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_param_weight_buffer
//  Purpose  : Directed, table-driven bench for param_weight_buffer with
//             default parameters. Beat payloads are generated from a base
//             value (word k = base + k + 1) and expected lane outputs are
//             computed from the same base and the expected tap index.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_param_weight_buffer;

  localparam int DW    = 8;
  localparam int LANES = 11;
  localparam int TAPS  = 7;
  localparam int WPB   = 9;

  logic                clk;
  logic                rst;
  logic                weight_valid;
  logic [WPB*DW-1:0]   weight_i;
  logic                weight_ready;
  logic                swap;
  logic                en_cnt;
  logic                shadow_full;
  logic                active_valid;
  logic                tap_last;
  logic [LANES*DW-1:0] para_weight_o;

  param_weight_buffer #(
    .DW    (DW),
    .LANES (LANES),
    .TAPS  (TAPS),
    .WPB   (WPB)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .weight_valid  (weight_valid),
    .weight_i      (weight_i),
    .weight_ready  (weight_ready),
    .swap          (swap),
    .en_cnt        (en_cnt),
    .shadow_full   (shadow_full),
    .active_valid  (active_valid),
    .tap_last      (tap_last),
    .para_weight_o (para_weight_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit rst;
    bit wv;
    int beat;     // beat index used to build weight_i
    int wbase;    // payload base for weight_i
    bit swap;
    bit en;
    bit e_ready;
    bit e_full;
    bit e_av;
    int e_base;   // -1: outputs all zero, otherwise base of the active set
    int e_tap;
  } vec_t;

  vec_t vecs[$];
  int   checks;
  int   failures;

  task automatic add(bit r, bit wv, int b, int wb, bit sw, bit en,
                     bit rdy, bit full, bit av, int eb, int et);
    vec_t v;
    v.rst = r;  v.wv = wv; v.beat = b; v.wbase = wb; v.swap = sw; v.en = en;
    v.e_ready = rdy; v.e_full = full; v.e_av = av; v.e_base = eb; v.e_tap = et;
    vecs.push_back(v);
  endtask

  function automatic logic [WPB*DW-1:0] beat_data(int base, int b);
    logic [WPB*DW-1:0] r;
    for (int j = 0; j < WPB; j++) r[j*DW +: DW] = DW'(base + b*WPB + j + 1);
    return r;
  endfunction

  function automatic logic [LANES*DW-1:0] exp_para(int base, int tap);
    logic [LANES*DW-1:0] r;
    for (int l = 0; l < LANES; l++)
      r[l*DW +: DW] = (base < 0) ? '0 : DW'(base + l*TAPS + tap + 1);
    return r;
  endfunction

  task automatic chk(string nm, int idx, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%0h expected=%0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(bit r, bit wv, logic [WPB*DW-1:0] d, bit sw, bit en);
    rst = r; weight_valid = wv; weight_i = d; swap = sw; en_cnt = en;
  endtask

  task automatic check_outs(int idx, bit rdy, bit full, bit av, int eb, int et);
    chk("weight_ready", idx, 128'(weight_ready), 128'(rdy));
    chk("shadow_full",  idx, 128'(shadow_full),  128'(full));
    chk("active_valid", idx, 128'(active_valid), 128'(av));
    chk("tap_last",     idx, 128'(tap_last),     128'(et == TAPS-1));
    chk("para_weight_o", idx, 128'(para_weight_o), 128'(exp_para(eb, et)));
  endtask

  initial begin
    int tap;
    bit en;
    checks   = 0;
    failures = 0;
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0);

    // ---- vector table -----------------------------------------------------
    add(1,0,0,0,0,0, 1,0,0,-1,0);                       // reset state
    for (int b = 0; b < 4; b++) add(0,1,b,0,0,0, 1,0,0,-1,0);
    add(0,0,0,0,1,0, 1,0,0,-1,0);                       // early swap: ignored
    for (int b = 4; b < 8; b++) add(0,1,b,0,0,0, 1,0,0,-1,0);
    add(0,1,8,0,0,0, 0,1,0,-1,0);                       // 9th beat -> FULL
    for (int i = 0; i < 5; i++) add(0,1,i,200,0,0, 0,1,0,-1,0); // ignored beats
    add(0,0,0,0,1,0, 1,0,1,0,0);                        // swap: set A, tap 0
    for (int i = 1; i <= 8; i++) add(0,0,0,0,0,1, 1,0,1,0,i % TAPS);
    tap = 1;                                            // load set B, en toggles
    for (int b = 0; b < 9; b++) begin
      en  = (b % 2) == 0;
      tap = en ? (tap + 1) % TAPS : tap;
      add(0,1,b,100,0,en, b < 8, b == 8, 1, 0, tap);
    end
    add(0,0,0,0,1,1, 1,0,1,100,0);                      // swap wins over en_cnt
    for (int b = 0; b < 5; b++) add(0,1,b,50,0,0, 1,0,1,100,0);
    add(1,0,0,0,0,0, 1,0,0,-1,0);                       // reset mid-fill
    for (int b = 0; b < 8; b++) add(0,1,b,20,0,0, 1,0,0,-1,0);
    add(0,1,8,20,0,0, 0,1,0,-1,0);
    add(0,0,0,0,1,0, 1,0,1,20,0);
    add(0,0,0,0,0,1, 1,0,1,20,1);
    add(0,0,0,0,0,1, 1,0,1,20,2);

    // ---- apply table ------------------------------------------------------
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].wv, beat_data(vecs[i].wbase, vecs[i].beat),
            vecs[i].swap, vecs[i].en);
      @(posedge clk); #1;
      check_outs(i, vecs[i].e_ready, vecs[i].e_full, vecs[i].e_av,
                 vecs[i].e_base, vecs[i].e_tap);
    end

    // ---- reset mid-read with every other input active ---------------------
    drive(1'b1, 1'b1, beat_data(60, 0), 1'b1, 1'b1);
    @(posedge clk); #1;
    check_outs(1000, 1'b1, 1'b0, 1'b0, -1, 0);

    // Tap index still cycles with an empty active bank; tap_last on tap 6.
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      check_outs(1000 + k, 1'b1, 1'b0, 1'b0, -1, k % TAPS);
    end

    // Hold: en_cnt low keeps tap at 0 for a few cycles.
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("tap_hold_last", 2000 + k, 128'(tap_last), 128'(0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
